q_mul_vec: RTL
==============

Q_MUL_VEC -- requirements
Module: q_mul_vec

Interface
REQ-001 SHALL have parameter LANES, default 4: number of parallel multiply lanes.
REQ-002 SHALL have parameter DW, default 8: width of each A/B/C lane element.
REQ-003 SHALL have parameter GW, default 32: width of the gain word MLC_GAGB.
REQ-004 SHALL have parameter SIGNED, default 0: 0 = unsigned A/B/C, 1 = two's-complement A/B/C; the gain is always unsigned.
REQ-005 SHALL have port CLK  in  1: single clock, all logic on the rising edge.
REQ-006 SHALL have port RESET  in  1: reset, synchronous and active-high.
REQ-007 SHALL have port INPUT_EN  in  1: input beat valid.
REQ-008 SHALL have port INPUT_RDY  out  1: block accepts an input beat this cycle.
REQ-009 SHALL have port A_IN  in  LANES*DW: packed operand A, lane 0 in LSBs.
REQ-010 SHALL have port B_IN  in  LANES*DW: packed operand B.
REQ-011 SHALL have port MLC_GAGB  in  GW: gain word, sampled per accepted beat.
REQ-012 SHALL have port MLC_SHIFT  in  6: right-shift amount, sampled per accepted beat.
REQ-013 SHALL have port OUTPUT_EN  out  1: output beat valid.
REQ-014 SHALL have port OUTPUT_RDY  in  1: downstream accepts the output beat.
REQ-015 SHALL have port C_OUT  out  LANES*DW: packed results.
REQ-016 SHALL have port SAT_OUT  out  LANES: per-lane saturation flag (only when Q_MUL_SAT_EN is defined; tied 0 otherwise).

Function
REQ-017 Per lane: P1 = A*B (2*DW bits); P2 = P1*GAGB (2*DW+GW bits, sign-extended in SIGNED mode); R = (P2 + 2^(SHIFT-1)) >>> SHIFT, round-half-up, with no rounding add when SHIFT=0.
REQ-018 With SHIFT >= 2*DW+GW, R SHALL be 0.
REQ-019 C lane = R[DW-1:0], unless saturation applies (REQ-028).
REQ-020 Pipeline SHALL have 3 stages: s1 multiply A*B and register GAGB/SHIFT; s2 multiply by gain; s3 round/shift/saturate. Latency is 3 cycles from acceptance to OUTPUT_EN when there is no stall.
REQ-021 Advance = OUTPUT_RDY OR NOT OUTPUT_EN; all stages move together only on advance.
REQ-022 INPUT_RDY = advance; a beat is accepted when INPUT_EN AND INPUT_RDY.
REQ-023 While stalled, C_OUT, SAT_OUT and OUTPUT_EN SHALL hold stable; no beat is lost or duplicated.
REQ-024 Bubbles SHALL propagate as invalid stages; throughput is 1 beat/cycle with OUTPUT_RDY held high.
REQ-025 GAGB/SHIFT changes SHALL affect only beats accepted after the change.

Reset
REQ-026 On RESET high at a clock edge: all stage valids cleared, OUTPUT_EN=0, C_OUT=0, SAT_OUT=0; in-flight beats are discarded.
REQ-027 INPUT_RDY SHALL be 1 during reset and in the first cycle after it (pipeline empty).

Configuration
REQ-028 With macro Q_MUL_SAT_EN defined: R is clamped to [0, 2^DW-1] when unsigned, or [-2^(DW-1), 2^(DW-1)-1] when SIGNED, and the SAT_OUT lane bit is 1 when the clamp is active, registered alongside C_OUT.
REQ-029 Without Q_MUL_SAT_EN: no clamp logic; C_OUT wraps (low DW bits); SAT_OUT=0.

Structure
REQ-030 Package q_mul_pkg SHALL hold the width constants/functions (P1W=2*DW, P2W=2*DW+GW, SHW=6) and the round/shift/saturate function.
REQ-031 Sub-module q_mul_lane SHALL implement one lane's datapath with enable; q_mul_vec instantiates LANES copies and owns the shared valid/stall control and GAGB/SHIFT registers.

Verification (LANES=4, DW=8, GW=32)
REQ-032 Basic: A=3, B=5, GAGB=0x00020000, SHIFT=17 on all lanes -> C=15 on every lane exactly 3 cycles after acceptance.
REQ-033 Rounding: A=1, B=1, GAGB=0x00010000, SHIFT=17 -> C=1 (0.5 rounds up); A=1, B=1, GAGB=0x0000FFFF -> C=0.
REQ-034 Saturation: A=255, B=255, GAGB=0x00020000, SHIFT=17 -> with Q_MUL_SAT_EN C=255, SAT_OUT=1; without it C=1, SAT_OUT=0.
REQ-035 Signed: SIGNED=1, A=0xFD (-3), B=5, GAGB=0x00020000, SHIFT=17 -> C=0xF1 (-15); A=0x80, B=0x80 -> C=0x7F with SAT_OUT=1 when Q_MUL_SAT_EN.
REQ-036 Back-pressure: stream 8 beats and drop OUTPUT_RDY for 5 cycles mid-stream -> INPUT_RDY=0 while full and stalled, outputs held stable, all 8 results appear in order with none lost or duplicated.
REQ-037 Reset mid-stream: assert RESET with 3 beats in flight -> OUTPUT_EN=0 next cycle and no stale beat emitted afterwards.

Source files
------------

// File: rtl/q_mul_pkg.sv
// Shared widths and the round / shift / saturate helpers for the q_mul vector multiplier.
// Arithmetic helpers work on a fixed 128-bit container so any lane width up to that fits.
package q_mul_pkg;

    localparam int SHW  = 6;
    localparam int MAXW = 128;

    typedef logic [MAXW-1:0] wide_t;

    function automatic int p1w(input int dw);
        return 2 * dw;
    endfunction

    function automatic int p2w(input int dw, input int gw);
        return 2 * dw + gw;
    endfunction

    // p2 arrives already sign/zero extended to MAXW, so the rounding add cannot overflow.
    function automatic wide_t round_shift(input wide_t p2, input logic [SHW-1:0] sh,
                                          input int width);
        wide_t sum;
        if (int'(sh) >= width) return '0;
        if (sh == '0) return p2;
        sum = p2 + (wide_t'(1) << (sh - SHW'(1)));
        sum = $signed(sum) >>> sh;
        return sum;
    endfunction

    function automatic wide_t sat_hi(input int dw, input logic sgn);
        if (sgn) return (wide_t'(1) << (dw - 1)) - wide_t'(1);
        return (wide_t'(1) << dw) - wide_t'(1);
    endfunction

    function automatic wide_t sat_lo(input int dw, input logic sgn);
        if (sgn) return ~sat_hi(dw, sgn);
        return '0;
    endfunction

    function automatic logic sat_hit(input wide_t r, input int dw, input logic sgn);
        if (sgn) return ($signed(r) > $signed(sat_hi(dw, sgn))) ||
                        ($signed(r) < $signed(sat_lo(dw, sgn)));
        return r > sat_hi(dw, sgn);
    endfunction

    function automatic wide_t sat_clamp(input wide_t r, input int dw, input logic sgn);
        if (!sat_hit(r, dw, sgn)) return r;
        if (sgn && r[MAXW-1]) return sat_lo(dw, sgn);
        return sat_hi(dw, sgn);
    endfunction

endpackage

// File: rtl/q_mul_lane.sv
// One lane of the gain-scaled multiplier: A*B, times gain, then round/shift (and clamp).
// Clamping and the saturation flag exist only when Q_MUL_SAT_EN is defined.
module q_mul_lane
    import q_mul_pkg::*;
#(
    parameter int DW     = 8,
    parameter int GW     = 32,
    parameter int SIGNED = 0
)(
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_en,
    input  logic [DW-1:0]  i_a,
    input  logic [DW-1:0]  i_b,
    input  logic [GW-1:0]  i_gain,
    input  logic [SHW-1:0] i_shift,
    output logic [DW-1:0]  o_c,
    output logic           o_sat
);

    localparam int   P1W = p1w(DW);
    localparam int   P2W = p2w(DW, GW);
    localparam logic SGN = (SIGNED != 0);

    logic [P1W-1:0] w_a_ext, w_b_ext, r_p1;
    logic [P2W-1:0] w_p1_ext, w_gain_ext, r_p2;
    wide_t          w_p2_wide;
    logic [DW-1:0]  w_c, r_c;
    logic           w_sat, r_sat;

    // Products are taken modulo their width, so extending operands first yields two's-complement results.
    assign w_a_ext    = SGN ? {{DW{i_a[DW-1]}}, i_a} : {{DW{1'b0}}, i_a};
    assign w_b_ext    = SGN ? {{DW{i_b[DW-1]}}, i_b} : {{DW{1'b0}}, i_b};
    assign w_p1_ext   = SGN ? {{GW{r_p1[P1W-1]}}, r_p1} : {{GW{1'b0}}, r_p1};
    assign w_gain_ext = {{P1W{1'b0}}, i_gain};
    assign w_p2_wide  = SGN ? {{(MAXW-P2W){r_p2[P2W-1]}}, r_p2}
                            : {{(MAXW-P2W){1'b0}}, r_p2};

`ifdef Q_MUL_SAT_EN
    wide_t w_r;
    assign w_r   = round_shift(w_p2_wide, i_shift, P2W);
    assign w_c   = DW'(sat_clamp(w_r, DW, SGN));
    assign w_sat = sat_hit(w_r, DW, SGN);
`else
    assign w_c   = DW'(round_shift(w_p2_wide, i_shift, P2W));
    assign w_sat = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_c   <= '0;
            r_sat <= 1'b0;
        end else if (i_en) begin
            r_p1  <= w_a_ext * w_b_ext;
            r_p2  <= w_p1_ext * w_gain_ext;
            r_c   <= w_c;
            r_sat <= w_sat;
        end
    end

    assign o_c   = r_c;
    assign o_sat = r_sat;

endmodule

// File: rtl/q_mul_vec.sv
// Vector of LANES gain-scaled multipliers behind a 3-stage valid/ready pipeline.
// Define Q_MUL_SAT_EN to enable output clamping and the SAT_OUT flags.
module q_mul_vec
    import q_mul_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int DW     = 8,
    parameter int GW     = 32,
    parameter int SIGNED = 0
)(
    input  logic                CLK,
    input  logic                RESET,
    input  logic                INPUT_EN,
    output logic                INPUT_RDY,
    input  logic [LANES*DW-1:0] A_IN,
    input  logic [LANES*DW-1:0] B_IN,
    input  logic [GW-1:0]       MLC_GAGB,
    input  logic [SHW-1:0]      MLC_SHIFT,
    output logic                OUTPUT_EN,
    input  logic                OUTPUT_RDY,
    output logic [LANES*DW-1:0] C_OUT,
    output logic [LANES-1:0]    SAT_OUT
);

    logic           r_v1, r_v2, r_v3;
    logic [GW-1:0]  r_gain_s1;
    logic [SHW-1:0] r_shift_s1, r_shift_s2;
    logic           w_adv, w_accept;

    // Whole pipeline moves as one; a full, stalled output freezes every stage.
    assign w_adv     = OUTPUT_RDY | ~r_v3;
    assign w_accept  = INPUT_EN & w_adv;
    assign INPUT_RDY = w_adv | RESET;
    assign OUTPUT_EN = r_v3;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (w_adv) begin
            r_v1       <= INPUT_EN;
            r_v2       <= r_v1;
            r_v3       <= r_v2;
            r_shift_s2 <= r_shift_s1;
            if (w_accept) begin
                r_gain_s1  <= MLC_GAGB;
                r_shift_s1 <= MLC_SHIFT;
            end
        end
    end

    for (genvar g_i = 0; g_i < LANES; g_i++) begin : g_lane
        q_mul_lane #(
            .DW     (DW),
            .GW     (GW),
            .SIGNED (SIGNED)
        ) u_lane (
            .i_clk   (CLK),
            .i_rst   (RESET),
            .i_en    (w_adv),
            .i_a     (A_IN[g_i*DW +: DW]),
            .i_b     (B_IN[g_i*DW +: DW]),
            .i_gain  (r_gain_s1),
            .i_shift (r_shift_s2),
            .o_c     (C_OUT[g_i*DW +: DW]),
            .o_sat   (SAT_OUT[g_i])
        );
    end

endmodule
